// File: rtl/maint_refresh_seq_pkg.sv
// maint_refresh_seq_pkg: instruction field offsets, command opcodes and sequencer states
package maint_refresh_seq_pkg;
  localparam int VALID_BIT = 31;
  localparam int CS_OFFSET = 22;
  localparam int RAS_OFFSET = 21;
  localparam int CAS_OFFSET = 20;
  localparam int WE_OFFSET = 19;
  localparam int PREA_BIT = 10;
  // {ras, cas, we}, all active-low
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  typedef enum logic [2:0] {IDLE, SCAN, PRE, WAIT_RP, REF, WAIT_RFC, RESTORE, DONE} state_t;
endpackage

// File: rtl/maint_instr_fmt.sv
// maint_instr_fmt: packs {cmd, bank, row} into a 32-bit maintenance instruction
module maint_instr_fmt
  import maint_refresh_seq_pkg::*;
#(
  parameter int ROW_WIDTH = 16,
  parameter int BANK_WIDTH = 3,
  parameter int CS_WIDTH = 1
) (
  input  logic [2:0]            cmd,
  input  logic [BANK_WIDTH-1:0] bank,
  input  logic [ROW_WIDTH-1:0]  row,
  output logic [31:0]           instr
);
  always_comb begin
    instr = '0;
    instr[VALID_BIT] = 1'b1;
    instr[CS_OFFSET +: CS_WIDTH] = '0;
    instr[RAS_OFFSET] = cmd[2];
    instr[CAS_OFFSET] = cmd[1];
    instr[WE_OFFSET] = cmd[0];
    instr[ROW_WIDTH +: BANK_WIDTH] = bank;
    instr[ROW_WIDTH-1:0] = row;
  end
endmodule

// File: rtl/maint_refresh_seq.sv
// maint_refresh_seq: snapshot open banks, PRE, REF, re-ACT; MAINT_PREA_EN selects a single precharge-all
module maint_refresh_seq
  import maint_refresh_seq_pkg::*;
#(
  parameter int ROW_WIDTH = 16,
  parameter int BANK_WIDTH = 3,
  parameter int CS_WIDTH = 1,
  parameter int T_RP = 8,
  parameter int T_RFC = 64,
  parameter int TCNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ref_req,
  output logic                  ref_busy,
  output logic                  ref_done,
  output logic [BANK_WIDTH-1:0] maint_bank,
  input  logic [ROW_WIDTH:0]    maint_bank_state,
  output logic [31:0]           mnt_instr,
  output logic                  mnt_valid,
  input  logic                  mnt_ready
);
  localparam int NUM_BANKS = 1 << BANK_WIDTH;
  state_t state, state_n;
  logic pending;
  logic [BANK_WIDTH-1:0] idx, lo, bank_f;
  logic [NUM_BANKS-1:0] open_mask, work, work_n, work_clr, scan_mask;
  logic [NUM_BANKS-1:0][ROW_WIDTH-1:0] row_snap;
  logic [TCNT_WIDTH-1:0] timer, timer_n;
  logic [ROW_WIDTH-1:0] row_f;
  logic [2:0] cmd;
  logic [31:0] fmt_instr;

  function automatic logic [BANK_WIDTH-1:0] lowest(input logic [NUM_BANKS-1:0] m);
    lowest = '0;
    for (int k = NUM_BANKS - 1; k >= 0; k--) if (m[k]) lowest = BANK_WIDTH'(k);
  endfunction

  maint_instr_fmt #(.ROW_WIDTH(ROW_WIDTH), .BANK_WIDTH(BANK_WIDTH), .CS_WIDTH(CS_WIDTH)) u_fmt (
    .cmd(cmd), .bank(bank_f), .row(row_f), .instr(fmt_instr)
  );

  // work holds the banks still to be precharged or re-activated
  always_comb begin
    state_n = state;
    timer_n = timer;
    work_n = work;
    scan_mask = open_mask;
    scan_mask[idx] = maint_bank_state[ROW_WIDTH];
    lo = lowest(work);
    work_clr = work & ~(NUM_BANKS'(1) << lo);
    cmd = CMD_ACT;
    bank_f = lo;
    row_f = row_snap[lo];
    mnt_valid = 1'b0;
    case (state)
      IDLE: if (pending || ref_req) state_n = SCAN;
      SCAN: begin
        work_n = scan_mask;
        if (idx == BANK_WIDTH'(NUM_BANKS - 1)) state_n = |scan_mask ? PRE : REF;
      end
      PRE: begin
        mnt_valid = 1'b1;
        cmd = CMD_PRE;
`ifdef MAINT_PREA_EN
        bank_f = '0;
        row_f = ROW_WIDTH'(1) << PREA_BIT;
        if (mnt_ready) begin
          timer_n = TCNT_WIDTH'(T_RP);
          state_n = WAIT_RP;
        end
`else
        row_f = '0;
        if (mnt_ready) begin
          work_n = work_clr;
          if (work_clr == '0) begin
            timer_n = TCNT_WIDTH'(T_RP);
            state_n = WAIT_RP;
          end
        end
`endif
      end
      WAIT_RP, WAIT_RFC: begin
        timer_n = timer == '0 ? timer : timer - 1'b1;
        work_n = open_mask;
        if (timer <= TCNT_WIDTH'(1)) state_n = state == WAIT_RP ? REF : (|open_mask ? RESTORE : DONE);
      end
      REF: begin
        mnt_valid = 1'b1;
        cmd = CMD_REF;
        bank_f = '0;
        row_f = '0;
        if (mnt_ready) begin
          timer_n = TCNT_WIDTH'(T_RFC);
          state_n = WAIT_RFC;
        end
      end
      RESTORE: begin
        mnt_valid = 1'b1;
        if (mnt_ready) begin
          work_n = work_clr;
          if (work_clr == '0) state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pending <= 1'b0;
      idx <= '0;
      open_mask <= '0;
      row_snap <= '0;
      work <= '0;
      timer <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      work <= work_n;
      pending <= state != IDLE && (pending || ref_req);
      idx <= state == SCAN ? idx + 1'b1 : '0;
      if (state == SCAN) begin
        open_mask <= scan_mask;
        row_snap[idx] <= maint_bank_state[ROW_WIDTH-1:0];
      end
    end
  end

  assign ref_busy = state != IDLE && state != DONE;
  assign ref_done = state == DONE;
  assign maint_bank = state == SCAN ? idx : '0;
  assign mnt_instr = mnt_valid ? fmt_instr : '0;
endmodule

// File: tb/tb_maint_refresh_seq.sv
// tb_maint_refresh_seq: table-driven refresh scenarios plus overlap and reset sequences
module tb_maint_refresh_seq;
  localparam int NB = 8;
  localparam int T_RP = 8;
  localparam int T_RFC = 64;
  logic clk = 0, rst_n = 0, ref_req = 0, mnt_ready = 1;
  logic ref_busy, ref_done, mnt_valid;
  logic [2:0] maint_bank;
  logic [16:0] maint_bank_state;
  logic [31:0] mnt_instr;
  logic [NB-1:0] bank_open = '0;
  logic [NB-1:0][15:0] bank_row = '0;
  int n_checks = 0, n_fail = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [7:0] open;
    logic [7:0][15:0] rows;
    logic toggle;
    int n_xfer;
    logic [31:0] first;
    int done_lat;
  } vec_t;
  vec_t vecs[5];

  assign maint_bank_state = {bank_open[maint_bank], bank_row[maint_bank]};
  always #5 clk = ~clk;

  maint_refresh_seq #(.ROW_WIDTH(16), .BANK_WIDTH(3), .CS_WIDTH(1), .T_RP(T_RP), .T_RFC(T_RFC), .TCNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ref_req(ref_req), .ref_busy(ref_busy), .ref_done(ref_done),
    .maint_bank(maint_bank), .maint_bank_state(maint_bank_state), .mnt_instr(mnt_instr),
    .mnt_valid(mnt_valid), .mnt_ready(mnt_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic build_exp(input logic [7:0] open, input logic [7:0][15:0] rows);
    exp_q.delete();
`ifdef MAINT_PREA_EN
    if (|open) exp_q.push_back(32'h8010_0400);
`else
    for (int b = 0; b < NB; b++) if (open[b]) exp_q.push_back(32'h8010_0000 | (32'(b) << 16));
`endif
    exp_q.push_back(32'h8008_0000);
    for (int b = 0; b < NB; b++) if (open[b]) exp_q.push_back(32'h8018_0000 | (32'(b) << 16) | 32'(rows[b]));
  endtask

  task automatic run_seq(input vec_t v, input int id);
    logic [31:0] got[$];
    logic [31:0] pi = '0;
    logic pv = 0, pr = 0, done = 0;
    int cyc = 0, c_pre = -1, c_ref = -1, c_act = -1;
    bank_open = v.open;
    bank_row = v.rows;
    build_exp(v.open, v.rows);
    @(negedge clk);
    ref_req = 1;
    mnt_ready = 1;
    while (cyc < 400 && !done) begin
      @(posedge clk);
      #1 ref_req = 0;
      cyc++;
      mnt_ready = v.toggle ? ~mnt_ready : 1'b1;
      @(negedge clk);
      if (pv && !pr) begin
        chk($sformatf("v%0d_stall_valid", id), mnt_valid, 1);
        chk($sformatf("v%0d_stall_instr", id), mnt_instr, pi);
      end
      if (mnt_valid && mnt_ready) begin
        got.push_back(mnt_instr);
        if (mnt_instr[21:19] == 3'b010) c_pre = cyc;
        if (mnt_instr[21:19] == 3'b001) c_ref = cyc;
        if (mnt_instr[21:19] == 3'b011 && c_act < 0) c_act = cyc;
      end
      if (ref_done) begin
        done = 1;
        chk($sformatf("v%0d_busy_in_done", id), ref_busy, 0);
        if (v.done_lat > 0) chk($sformatf("v%0d_done_latency", id), cyc, v.done_lat);
      end
      pv = mnt_valid;
      pr = mnt_ready;
      pi = mnt_instr;
    end
    chk($sformatf("v%0d_done_seen", id), done, 1);
    chk($sformatf("v%0d_xfer_count", id), got.size(), v.n_xfer);
    chk($sformatf("v%0d_xfer_count_model", id), got.size(), exp_q.size());
    if (got.size() > 0) chk($sformatf("v%0d_first_instr", id), got[0], v.first);
    foreach (exp_q[i]) chk($sformatf("v%0d_instr%0d", id, i), i < got.size() ? got[i] : 32'hDEAD_DEAD, exp_q[i]);
    if (c_pre > 0 && c_ref > 0) chk($sformatf("v%0d_trp_gap", id), c_ref - c_pre > T_RP, 1);
    if (c_ref > 0 && c_act > 0) chk($sformatf("v%0d_trfc_gap", id), c_act - c_ref > T_RFC, 1);
    mnt_ready = 1;
    @(negedge clk);
    chk($sformatf("v%0d_idle_busy", id), ref_busy, 0);
    chk($sformatf("v%0d_idle_valid", id), mnt_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dones, refs;
    vecs[0] = '{open: 8'h00, rows: '0, toggle: 0, n_xfer: 1, first: 32'h8008_0000, done_lat: 74};
    vecs[1] = '{open: 8'h24, rows: '0, toggle: 0, n_xfer: 5, first: 32'h8012_0000, done_lat: 86};
    vecs[1].rows[2] = 16'h1234;
    vecs[1].rows[5] = 16'h00FF;
    vecs[2] = vecs[1];
    vecs[2].toggle = 1;
    vecs[2].done_lat = 0;
    vecs[3] = '{open: 8'hFF, rows: '0, toggle: 0, n_xfer: 17, first: 32'h8010_0000, done_lat: 0};
    for (int b = 0; b < NB; b++) vecs[3].rows[b] = 16'hF000 | 16'(b * 16'h0111);
    vecs[4] = '{open: 8'h81, rows: '0, toggle: 0, n_xfer: 5, first: 32'h8010_0000, done_lat: 0};
    vecs[4].rows[0] = 16'hABCD;
    vecs[4].rows[7] = 16'h0001;
`ifdef MAINT_PREA_EN
    vecs[1].n_xfer = 4; vecs[1].first = 32'h8010_0400; vecs[1].done_lat = 85;
    vecs[2].n_xfer = 4; vecs[2].first = 32'h8010_0400;
    vecs[3].n_xfer = 10; vecs[3].first = 32'h8010_0400;
    vecs[4].n_xfer = 4; vecs[4].first = 32'h8010_0400;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", ref_busy, 0);
    chk("rst_done", ref_done, 0);
    chk("rst_valid", mnt_valid, 0);
    chk("rst_instr", mnt_instr, 0);
    chk("rst_bank", maint_bank, 0);
    rst_n = 1;
    foreach (vecs[i]) run_seq(vecs[i], i);

    // two extra requests while busy merge into one further sequence
    bank_open = '0;
    dones = 0;
    refs = 0;
    @(negedge clk);
    ref_req = 1;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk);
      #1 ref_req = (c == 5 || c == 30);
      @(negedge clk);
      if (ref_done) dones++;
      if (mnt_valid && mnt_ready && mnt_instr == 32'h8008_0000) refs++;
    end
    ref_req = 0;
    chk("overlap_done_pulses", dones, 2);
    chk("overlap_ref_count", refs, 2);

    // reset during WAIT_RFC
    @(negedge clk);
    ref_req = 1;
    repeat (20) begin
      @(posedge clk);
      #1 ref_req = 0;
    end
    @(negedge clk);
    chk("wrfc_busy_before_rst", ref_busy, 1);
    rst_n = 0;
    @(negedge clk);
    chk("wrfc_rst_valid", mnt_valid, 0);
    chk("wrfc_rst_busy", ref_busy, 0);
    rst_n = 1;
    dones = 0;
    repeat (100) begin
      @(negedge clk);
      if (ref_done) dones++;
    end
    chk("wrfc_rst_no_done", dones, 0);

    // reset while a PRE is stalled
    bank_open = 8'h24;
    mnt_ready = 0;
    @(negedge clk);
    ref_req = 1;
    repeat (12) begin
      @(posedge clk);
      #1 ref_req = 0;
    end
    @(negedge clk);
    chk("stall_pre_valid", mnt_valid, 1);
    rst_n = 0;
    @(negedge clk);
    chk("stall_rst_valid", mnt_valid, 0);
    chk("stall_rst_instr", mnt_instr, 0);
    rst_n = 1;
    mnt_ready = 1;
    repeat (2) @(negedge clk);
    run_seq(vecs[0], 5);
    run_seq(vecs[1], 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
